// File: rtl/gb_bus_defs.sv
// Game Boy bus address map and DMA state encoding.
// Shared by the DMA controller, the bus arbiter and the benches.
package gb_bus_defs;

  localparam logic [15:0] REG_DMA  = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam int          OAM_SIZE = 160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dmaState_t;

  // Echo RAM at E000-FDFF mirrors C000-DDFF, so source pages at E0 and above fold down by 0x20.
  function automatic logic [7:0] foldSourcePage(input logic [7:0] page);
    return (page >= 8'hE0) ? page - 8'h20 : page;
  endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA bus initiator: copies LENGTH bytes from page {src,00} to DEST_BASE, two cycles per byte.
// Armed by snooping a CPU write to REG_ADDR; a later write to REG_ADDR restarts the copy from byte 0.
module oam_dma_controller
  import gb_bus_defs::*;
#(
  parameter logic [15:0] REG_ADDR    = REG_DMA,
  parameter logic [15:0] DEST_BASE   = OAM_BASE,
  parameter int          LENGTH      = OAM_SIZE,
  parameter int          START_DELAY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_write,
  input  logic        cpu_nread,
  input  logic        cpu_nwrite,
  output logic [7:0]  cpu_data_read,
  output logic [15:0] dma_address,
  output logic [7:0]  dma_data_write,
  input  logic [7:0]  dma_data_read,
  output logic        dma_nread,
  output logic        dma_nwrite,
  output logic        dma_active
);

  localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);
  localparam logic [1:0] DELAY_LOAD = 2'(START_DELAY - 1);

  dmaState_t   r_state;
  logic [7:0]  r_srcReg;
  logic [7:0]  r_index;
  logic [7:0]  r_latch;
  logic [1:0]  r_delayCnt;
  logic [15:0] r_dmaAddress;
  logic        r_dmaNread;
  logic        r_dmaNwrite;
  logic        r_dmaActive;

  logic       w_trigger;
  logic       w_regSelect;
  logic [7:0] w_srcEff;

  assign w_trigger   = !cpu_nwrite && (cpu_address == REG_ADDR);
  assign w_regSelect = !cpu_nread && (cpu_address == REG_ADDR);
  assign w_srcEff    = foldSourcePage(r_srcReg);

  assign cpu_data_read  = w_regSelect ? r_srcReg : 8'bz;
  assign dma_address    = r_dmaAddress;
  assign dma_data_write = r_latch;
  assign dma_nread      = r_dmaNread;
  assign dma_nwrite     = r_dmaNwrite;
  assign dma_active     = r_dmaActive;

  // Outputs are computed for the state being entered, so every master signal comes straight from a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_srcReg     <= 8'h00;
      r_index      <= 8'h00;
      r_latch      <= 8'h00;
      r_delayCnt   <= 2'd0;
      r_dmaAddress <= 16'h0000;
      r_dmaNread   <= 1'b1;
      r_dmaNwrite  <= 1'b1;
      r_dmaActive  <= 1'b0;
    end else if (w_trigger) begin
      r_srcReg    <= cpu_data_write;
      r_index     <= 8'h00;
      r_latch     <= 8'h00;
      r_dmaNwrite <= 1'b1;
      r_dmaActive <= 1'b1;
      if (START_DELAY == 0) begin
        r_state      <= READ;
        r_dmaAddress <= {foldSourcePage(cpu_data_write), 8'h00};
        r_dmaNread   <= 1'b0;
      end else begin
        r_state      <= START;
        r_delayCnt   <= DELAY_LOAD;
        r_dmaAddress <= 16'h0000;
        r_dmaNread   <= 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_dmaNread  <= 1'b1;
          r_dmaNwrite <= 1'b1;
        end
        START: begin
          if (r_delayCnt == 2'd0) begin
            r_state      <= READ;
            r_dmaAddress <= {w_srcEff, r_index};
            r_dmaNread   <= 1'b0;
          end else begin
            r_delayCnt <= r_delayCnt - 2'd1;
          end
        end
        READ: begin
          r_state      <= WRITE;
          r_latch      <= dma_data_read;
          r_dmaAddress <= DEST_BASE + {8'h00, r_index};
          r_dmaNread   <= 1'b1;
          r_dmaNwrite  <= 1'b0;
        end
        WRITE: begin
          r_dmaNwrite <= 1'b1;
          if (r_index == LAST_INDEX) begin
            r_state      <= IDLE;
            r_latch      <= 8'h00;
            r_dmaAddress <= 16'h0000;
            r_dmaActive  <= 1'b0;
          end else begin
            r_state      <= READ;
            r_index      <= r_index + 8'd1;
            r_dmaAddress <= {w_srcEff, r_index + 8'd1};
            r_dmaNread   <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_dmaNread  <= 1'b1;
          r_dmaNwrite <= 1'b1;
          r_dmaActive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: 64K byte memory responder, transfer-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_oam_dma_controller;

  localparam int SD    = 1;
  localparam int LEN   = 160;
  localparam int TOTAL = SD + 2 * LEN;

  logic        clock;
  logic        reset;
  logic [15:0] cpuAddress;
  logic [7:0]  cpuDataWrite;
  logic        cpuNread;
  logic        cpuNwrite;
  wire  [7:0]  cpuDataRead;
  logic [15:0] dmaAddress;
  logic [7:0]  dmaDataWrite;
  logic [7:0]  dmaDataRead;
  logic        dmaNread;
  logic        dmaNwrite;
  logic        dmaActive;

  logic [7:0] mem [65536];

  int vecCount = 0;
  int errCount = 0;

  int         mCycle;
  bit         mActive;
  logic [7:0] mSrc;

  oam_dma_controller dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_address   (cpuAddress),
    .cpu_data_write(cpuDataWrite),
    .cpu_nread     (cpuNread),
    .cpu_nwrite    (cpuNwrite),
    .cpu_data_read (cpuDataRead),
    .dma_address   (dmaAddress),
    .dma_data_write(dmaDataWrite),
    .dma_data_read (dmaDataRead),
    .dma_nread     (dmaNread),
    .dma_nwrite    (dmaNwrite),
    .dma_active    (dmaActive)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory responder: combinational read data, write captured on the edge that ends a write strobe.
  assign dmaDataRead = mem[dmaAddress];
  always @(posedge clock) begin
    if (!dmaNwrite) mem[dmaAddress] = dmaDataWrite;
  end

  // Reference model: only tracks which transfer is running and how many cycles it has been active.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mActive <= 1'b0;
      mCycle  <= 0;
      mSrc    <= 8'h00;
    end else if (!cpuNwrite && cpuAddress == 16'hFF46) begin
      mActive <= 1'b1;
      mCycle  <= 0;
      mSrc    <= cpuDataWrite;
    end else if (mActive) begin
      mCycle <= mCycle + 1;
      if (mCycle + 1 == TOTAL) mActive <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare: byte i is read at offset SD+2i and written at SD+2i+1.
  always @(negedge clock) begin
    int j;
    int i;
    logic [7:0]  pg;
    logic [15:0] rdAddr;
    if (!reset) begin
      if (!mActive) begin
        checkOutput("idle_active", {15'd0, dmaActive}, 16'd0);
        checkOutput("idle_nread",  {15'd0, dmaNread},  16'd1);
        checkOutput("idle_nwrite", {15'd0, dmaNwrite}, 16'd1);
        checkOutput("idle_addr",   dmaAddress,         16'h0000);
        checkOutput("idle_data",   {8'd0, dmaDataWrite}, 16'h0000);
      end else if (mCycle < SD) begin
        checkOutput("start_active", {15'd0, dmaActive}, 16'd1);
        checkOutput("start_nread",  {15'd0, dmaNread},  16'd1);
        checkOutput("start_nwrite", {15'd0, dmaNwrite}, 16'd1);
      end else begin
        j      = mCycle - SD;
        i      = j / 2;
        pg     = (mSrc >= 8'hE0) ? mSrc - 8'h20 : mSrc;
        rdAddr = {pg, 8'(i)};
        checkOutput("xfer_active", {15'd0, dmaActive}, 16'd1);
        if (j % 2 == 0) begin
          checkOutput("read_nread",  {15'd0, dmaNread},  16'd0);
          checkOutput("read_nwrite", {15'd0, dmaNwrite}, 16'd1);
          checkOutput("read_addr",   dmaAddress,         rdAddr);
        end else begin
          checkOutput("write_nread",  {15'd0, dmaNread},  16'd1);
          checkOutput("write_nwrite", {15'd0, dmaNwrite}, 16'd0);
          checkOutput("write_addr",   dmaAddress,         16'hFE00 + 16'(i));
          checkOutput("write_data",   {8'd0, dmaDataWrite}, {8'd0, mem[rdAddr]});
        end
      end
    end
  end

  // One CPU write cycle; returns just after the edge that samples it.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clock);
    #1;
    cpuAddress   = addr;
    cpuDataWrite = data;
    cpuNwrite    = 1'b0;
    @(posedge clock);
    #1;
    cpuNwrite    = 1'b1;
    cpuAddress   = 16'h0000;
    cpuDataWrite = 8'h00;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (dmaActive && n < 1000) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, {15'd0, dmaActive}, 16'd0);
  endtask

  initial begin
    int activeCnt;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    reset        = 1'b1;
    cpuAddress   = 16'h0000;
    cpuDataWrite = 8'h00;
    cpuNread     = 1'b1;
    cpuNwrite    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state, then idle
    repeat (10) @(negedge clock);
    checkOutput("t1_active", {15'd0, dmaActive}, 16'd0);
    checkOutput("t1_nread",  {15'd0, dmaNread},  16'd1);
    checkOutput("t1_nwrite", {15'd0, dmaNwrite}, 16'd1);
    checkOutput("t1_addr",   dmaAddress,         16'h0000);

    // Full copy from page 80
    for (int i = 0; i < LEN; i++) mem[16'h8000 + 16'(i)] = 8'(i) ^ 8'h5A;
    applyStimulus(16'hFF46, 8'h80);
    @(negedge clock);
    checkOutput("t2_c0_active", {15'd0, dmaActive}, 16'd1);
    checkOutput("t2_c0_nread",  {15'd0, dmaNread},  16'd1);
    @(negedge clock);
    checkOutput("t2_c1_addr",  dmaAddress,         16'h8000);
    checkOutput("t2_c1_nread", {15'd0, dmaNread},  16'd0);
    @(negedge clock);
    checkOutput("t2_c2_addr",   dmaAddress,           16'hFE00);
    checkOutput("t2_c2_data",   {8'd0, dmaDataWrite}, 16'h005A);
    checkOutput("t2_c2_nwrite", {15'd0, dmaNwrite},   16'd0);
    repeat (318) @(negedge clock);
    checkOutput("t2_c320_addr", dmaAddress,           16'hFE9F);
    checkOutput("t2_c320_data", {8'd0, dmaDataWrite}, 16'h00C5);
    checkOutput("t2_c320_act",  {15'd0, dmaActive},   16'd1);
    @(negedge clock);
    checkOutput("t2_c321_active", {15'd0, dmaActive}, 16'd0);
    for (int i = 0; i < LEN; i++)
      checkOutput("t2_oam", {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, 8'(i) ^ 8'h5A});

    // Retrigger at cycle 100 with a different page
    for (int i = 0; i < LEN; i++) begin
      mem[16'hC000 + 16'(i)] = ~8'(i);
      mem[16'hD000 + 16'(i)] = 8'(i * 3 + 7);
    end
    applyStimulus(16'hFF46, 8'hC0);
    repeat (98) @(posedge clock);
    applyStimulus(16'hFF46, 8'hD0);
    activeCnt = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (dmaActive) activeCnt++;
      else break;
    end
    checkOutput("t4_active_cycles", 16'(activeCnt), 16'(TOTAL));
    for (int i = 0; i < LEN; i++)
      checkOutput("t4_oam", {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, 8'(i * 3 + 7)});

    // Echo-RAM fold and register readback
    for (int i = 0; i < LEN; i++) mem[16'hD100 + 16'(i)] = 8'(i + 8'h11);
    applyStimulus(16'hFF46, 8'hF1);
    @(negedge clock);
    @(negedge clock);
    checkOutput("t5_first_read", dmaAddress, 16'hD100);
    #1;
    cpuAddress = 16'hFF46;
    cpuNread   = 1'b0;
    #1;
    checkOutput("t5_readback", {8'd0, cpuDataRead}, 16'h00F1);
    cpuAddress = 16'hFF47;
    #1;
    vecCount++;
    if (cpuDataRead === 8'hF1) begin
      errCount++;
      $display("[TB] FAIL t5_unselected: got %h, required not driven with F1", cpuDataRead);
    end
    cpuNread   = 1'b1;
    cpuAddress = 16'h0000;
    waitIdle("t5_idle");
    for (int i = 0; i < LEN; i++)
      checkOutput("t5_oam", {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, 8'(i + 8'h11)});

    // Asynchronous reset at cycle 50 of a transfer
    for (int i = 0; i < LEN; i++) begin
      mem[16'h9000 + 16'(i)] = 8'(i + 1);
      mem[16'hFE00 + 16'(i)] = 8'hEE;
    end
    applyStimulus(16'hFF46, 8'h90);
    repeat (50) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_active", {15'd0, dmaActive}, 16'd0);
    checkOutput("t6_rst_nread",  {15'd0, dmaNread},  16'd1);
    checkOutput("t6_rst_nwrite", {15'd0, dmaNwrite}, 16'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (i < 24) checkOutput("t6_partial", {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, 8'(i + 1)});
      else        checkOutput("t6_untouched", {8'd0, mem[16'hFE00 + 16'(i)]}, 16'h00EE);
    end
    applyStimulus(16'hFF46, 8'h90);
    waitIdle("t6_idle");
    for (int i = 0; i < LEN; i++)
      checkOutput("t6_oam", {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, 8'(i + 1)});

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
